matrix_result_collector: RTL and testbench

//   Receiver/reader end of the multiplier result port. Captures the C stream
//   (c_out, c_valid, c_row, c_col, done) from matrix_mult_3x3 into an MxP

---
 rtl/matrix_result_collector.sv | 129 ++++++++++++
 tb/tb_matrix_result_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_collector.sv
// Collects the multiplier C stream into an MxP buffer and replays it row-major
// over a valid/ready port, flagging duplicate, missing, out-of-range and overrun results.
module matrix_result_collector #(
  parameter int M          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ROW_W      = 2,
  parameter int COL_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] c_in,
  input  logic                         c_valid_in,
  input  logic        [ROW_W-1:0]      c_row_in,
  input  logic        [COL_W-1:0]      c_col_in,
  input  logic                         mult_done,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic        [ROW_W-1:0]      out_row,
  output logic        [COL_W-1:0]      out_col,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         err_dup,
  output logic                         err_missing,
  output logic                         err_range,
  output logic                         err_overrun
);
  localparam int N     = M * P;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic signed [DATA_WIDTH-1:0] r_buf [N];
  logic [N-1:0]     r_bitmap;
  logic [IDX_W-1:0] r_idx;
  logic             r_done_q, r_frame_done;
  logic             r_err_dup, r_err_missing, r_err_range, r_err_overrun;

  logic             w_in_range, w_wr, w_done_rise, w_accept, w_last;
  logic [IDX_W-1:0] w_addr;
  logic [N-1:0]     w_wr_mask, w_bitmap_nxt;

  assign w_in_range   = (int'(c_row_in) < M) && (int'(c_col_in) < P);
  assign w_addr       = IDX_W'(int'(c_row_in) * P + int'(c_col_in));
  assign w_wr         = (r_state == COLLECT) && c_valid_in && w_in_range;
  assign w_wr_mask    = w_wr ? (N'(1) << w_addr) : '0;
  // Includes a write landing in the same cycle as done, so missing-check sees it
  assign w_bitmap_nxt = r_bitmap | w_wr_mask;
  assign w_done_rise  = mult_done & ~r_done_q;
  assign w_accept     = (r_state == DRAIN) && out_ready;
  assign w_last       = (r_idx == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= COLLECT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: if (w_done_rise)         w_state_nxt = DRAIN;
      DRAIN:   if (w_accept && w_last)  w_state_nxt = COLLECT;
      default:                          w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bitmap      <= '0;
      r_idx         <= '0;
      r_done_q      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_dup     <= 1'b0;
      r_err_missing <= 1'b0;
      r_err_range   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_done_q     <= mult_done;
      r_frame_done <= w_accept && w_last;
      case (r_state)
        COLLECT: begin
          r_bitmap <= w_bitmap_nxt;
          if (c_valid_in && w_in_range && r_bitmap[w_addr]) r_err_dup <= 1'b1;
          if (c_valid_in && !w_in_range)                    r_err_range <= 1'b1;
          if (w_done_rise) begin
            r_idx <= '0;
            if (!(&w_bitmap_nxt)) r_err_missing <= 1'b1;
          end
        end
        DRAIN: begin
          if (c_valid_in) r_err_overrun <= 1'b1;
          if (w_accept) begin
            if (w_last) begin
              // Errors describe the frame just drained; clear on return to COLLECT
              r_idx         <= '0;
              r_bitmap      <= '0;
              r_err_dup     <= 1'b0;
              r_err_missing <= 1'b0;
              r_err_range   <= 1'b0;
              r_err_overrun <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_buf[w_addr] <= c_in;
  end

  assign out_valid   = (r_state == DRAIN);
  assign busy        = out_valid;
  assign out_data    = (out_valid && r_bitmap[r_idx]) ? r_buf[r_idx] : '0;
  assign out_row     = out_valid ? ROW_W'(r_idx / IDX_W'(P)) : '0;
  assign out_col     = out_valid ? COL_W'(r_idx % IDX_W'(P)) : '0;
  assign out_last    = out_valid && w_last;
  assign frame_done  = r_frame_done;
  assign err_dup     = r_err_dup;
  assign err_missing = r_err_missing;
  assign err_range   = r_err_range;
  assign err_overrun = r_err_overrun;
endmodule

// File: tb/tb_matrix_result_collector.sv
// Scoreboard bench: stimulus pushes expected replay beats, a negedge monitor
// compares every presented beat against the queue head and pops on acceptance.
module tb_matrix_result_collector;
  logic clk = 1'b0;
  logic rst, c_valid_in, mult_done, out_ready;
  logic signed [31:0] c_in, out_data;
  logic [1:0] c_row_in, c_col_in, out_row, out_col;
  logic out_valid, out_last, frame_done, busy;
  logic err_dup, err_missing, err_range, err_overrun;

  always #5 clk = ~clk;

  matrix_result_collector dut (
    .clk(clk), .rst(rst), .c_in(c_in), .c_valid_in(c_valid_in),
    .c_row_in(c_row_in), .c_col_in(c_col_in), .mult_done(mult_done),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done), .busy(busy), .err_dup(err_dup),
    .err_missing(err_missing), .err_range(err_range), .err_overrun(err_overrun)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int checks = 0, errors = 0, beats = 0;
  int vals[9];
  logic [8:0] present;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data %0d row %0d col %0d, expected no beat",
                 out_data, out_row, out_col);
      end else begin
        if (out_data !== sb[0].data || out_row !== sb[0].row ||
            out_col !== sb[0].col || out_last !== sb[0].last) begin
          errors++;
          $display("FAIL beat: got d=%0d r=%0d c=%0d l=%0b expected d=%0d r=%0d c=%0d l=%0b",
                   out_data, out_row, out_col, out_last,
                   sb[0].data, sb[0].row, sb[0].col, sb[0].last);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          beats++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int c, input int v);
    c_valid_in = 1'b1;
    c_row_in   = 2'(r);
    c_col_in   = 2'(c);
    c_in       = v;
    cyc();
    c_valid_in = 1'b0;
  endtask

  task automatic set_vals(input int base);
    for (int i = 0; i < 9; i++) vals[i] = base + i;
    present = '1;
  endtask

  task automatic push_frame();
    beat_t b;
    for (int i = 0; i < 9; i++) begin
      b.data = present[i] ? vals[i] : 0;
      b.row  = 2'(i / 3);
      b.col  = 2'(i % 3);
      b.last = (i == 8);
      sb.push_back(b);
    end
    beats = 0;
  endtask

  task automatic send_rowmajor();
    for (int i = 0; i < 9; i++)
      if (present[i]) send(i / 3, i % 3, vals[i]);
  endtask

  task automatic done_pulse();
    mult_done = 1'b1;
    cyc();
    mult_done = 1'b0;
  endtask

  // Runs the drain to completion, bounded, then checks pulse shape and error clear
  task automatic finish_frame(input bit toggle, input bit inject, input string nm);
    bit seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (toggle) out_ready = (k % 3 == 0);
      if (inject && k == 4) begin
        c_valid_in = 1'b1; c_row_in = 2'd0; c_col_in = 2'd0; c_in = 555;
      end else begin
        c_valid_in = 1'b0;
      end
      cyc();
      if (inject && k == 4) chk({nm, "_err_overrun_set"}, 32'(err_overrun), 1);
      if (frame_done) begin seen = 1; break; end
    end
    out_ready  = 1'b1;
    c_valid_in = 1'b0;
    chk({nm, "_frame_done_seen"}, 32'(seen), 1);
    chk({nm, "_beats"}, beats, 9);
    chk({nm, "_sb_empty"}, sb.size(), 0);
    cyc();
    chk({nm, "_frame_done_pulse"}, 32'(frame_done), 0);
    chk({nm, "_busy_after"}, 32'(busy), 0);
    chk({nm, "_errs_cleared"}, {28'd0, err_dup, err_missing, err_range, err_overrun}, 0);
  endtask

  initial begin
    int fd;
    rst = 1'b0; c_valid_in = 1'b0; mult_done = 1'b0; out_ready = 1'b1;
    c_in = 0; c_row_in = 0; c_col_in = 0;
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_errs", {28'd0, err_dup, err_missing, err_range, err_overrun}, 0);
    rst = 1'b1;
    cyc();

    // 1: row-major 1..9
    set_vals(1); push_frame(); send_rowmajor(); done_pulse();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_errs", {28'd0, err_dup, err_missing, err_range, err_overrun}, 0);
    finish_frame(0, 0, "t1");

    // 2: reverse order, done held high across the whole drain
    set_vals(1); push_frame();
    for (int i = 8; i >= 0; i--) send(i / 3, i % 3, vals[i]);
    mult_done = 1'b1; fd = 0;
    for (int k = 0; k < 14; k++) begin cyc(); if (frame_done) fd++; end
    mult_done = 1'b0;
    cyc(); cyc();
    chk("t2_frames", fd, 1);
    chk("t2_beats", beats, 9);
    chk("t2_busy", 32'(busy), 0);

    // 3: (1,1) missing
    set_vals(1); present[4] = 1'b0; push_frame(); send_rowmajor(); done_pulse();
    chk("t3_err_missing", 32'(err_missing), 1);
    finish_frame(0, 0, "t3");

    // 4: duplicate and out-of-range writes
    set_vals(1); vals[0] = 42; present = '1; push_frame();
    send(0, 0, 7); send(0, 0, 42); send(3, 0, 99);
    for (int i = 1; i < 9; i++) send(i / 3, i % 3, vals[i]);
    done_pulse();
    chk("t4_err_dup", 32'(err_dup), 1);
    chk("t4_err_range", 32'(err_range), 1);
    chk("t4_err_missing", 32'(err_missing), 0);
    finish_frame(0, 0, "t4");

    // 5: stalled drain plus overrun write
    set_vals(1); push_frame(); send_rowmajor(); done_pulse();
    finish_frame(1, 1, "t5");

    // 6: reset while beat 4 is presented, then a fresh frame
    set_vals(1); push_frame(); send_rowmajor(); done_pulse();
    cyc(); cyc(); cyc();
    rst = 1'b0; out_ready = 1'b0;
    cyc();
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_beats_before", beats, 3);
    sb.delete();
    rst = 1'b1; out_ready = 1'b1;
    cyc();
    chk("t6_frame_done", 32'(frame_done), 0);
    set_vals(10); push_frame(); send_rowmajor(); done_pulse();
    chk("t6_errs", {28'd0, err_dup, err_missing, err_range, err_overrun}, 0);
    finish_frame(0, 0, "t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
